dmem_unit: RTL

DMEM_UNIT -- requirements
Module: dmem_unit

---
 rtl/dmem_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dmem_unit.sv
// dmem_unit: single-port data memory with a valid/ready request channel and
// a valid/ready response channel. One access is in flight at a time.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 32-bit words (default 1024 words)
//   BASE_ADDR  - byte address of word 0, 4-byte aligned
//
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   req_valid/ready  - request handshake (ready only in IDLE)
//   req_write        - 1 store, 0 load
//   req_size         - 00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned     - zero-extend loads when 1, sign-extend when 0
//   req_addr         - byte address
//   req_wdata        - right-aligned store data
//   rsp_valid/ready  - response handshake
//   rsp_rdata        - extended load data, 0 for stores and errors
//   rsp_err          - access faulted (range, reserved size, misalignment)
//   dbg_state_o      - current FSM state, for observation only
//
// Build option:
//   DMEM_MISALIGN_CHECK_EN - when defined, misaligned half/word accesses fault.
//   When undefined, misaligned low address bits are ignored.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the producer holds its payload stable until then, and the response
// payload is held stable while rsp_valid=1 and rsp_ready=0.
module dmem_unit #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned OFF_HI = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  // Datapath signals derived from the latched request
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  range_err, size_err, align_err, acc_err;
  logic [3:0]            be;
  logic [31:0]           wline, rd_word, ld_val;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    off  = addr_q - BASE_ADDR;
    idx  = off[OFF_HI-1:2];
    // BASE_ADDR is word aligned, so the low offset bits are the byte lane
    lane = off[1:0];
    // Below-base addresses wrap to a huge offset; the explicit compare keeps
    // that case obvious.
    range_err = (addr_q < BASE_ADDR) || (off[31:OFF_HI] != '0);
    size_err  = (size_q == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
    align_err = ((size_q == 2'b01) && lane[0]) ||
                ((size_q == 2'b10) && (lane != 2'b00));
`else
    align_err = 1'b0;
`endif
    acc_err = range_err || size_err || align_err;

    // Half accesses select their lane pair by addr[1] only
    case (size_q)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase

    // Replicate narrow data across the word so byte enables pick it up
    case (size_q)
      2'b00:   wline = {4{wdata_q[7:0]}};
      2'b01:   wline = {2{wdata_q[15:0]}};
      default: wline = wdata_q;
    endcase

    rd_word = mem[idx];
    ld_b    = rd_word[{lane, 3'b000} +: 8];
    ld_h    = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   ld_val = unsigned_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_val = unsigned_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_val = rd_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready) begin
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
      if (state_q == ST_ACCESS) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || write_q) ? '0 : ld_val;
      end
    end
  end

  // Memory array has no reset. Reset forces the FSM out of ACCESS
  // asynchronously, so a pending store never reaches this block.
  always_ff @(posedge clk) begin
    if ((state_q == ST_ACCESS) && write_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wline[8*i +: 8];
      end
    end
  end

endmodule
